// File: rtl/ps2_data_in_rx.sv
// ps2_data_in_rx: device-to-host PS/2 receiver.
// Deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop) from
// the open-drain ps2_clk/ps2_data lines and emits one 1-cycle strobe per frame:
// a good byte, a parity error, a framing error, or an edge timeout.
// Optional feature macro: PS2_RX_GLITCH_FILTER_EN. When it is defined, ps2_clk
// must hold a new level for FILTER_CYCLES cycles before that level is accepted.
module ps2_data_in_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rx_enable,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       framing_error,
   output logic       timeout_error,
   output logic [3:0] debug
);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nx;
   logic        clk_s1, clk_s2, data_s1, data_s2;
   logic        clk_flt, clk_flt_q, fall;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        par_q;
   logic [15:0] to_cnt;
   logic        to_hit;
   logic        good_c, perr_c, ferr_c, terr_c;

   // Two-flop synchronisers for both asynchronous lines. They clear to 0 so
   // that a line already low when reset releases cannot look like a falling edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_s1  <= 1'b0;
         clk_s2  <= 1'b0;
         data_s1 <= 1'b0;
         data_s2 <= 1'b0;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   logic [FW-1:0] flt_cnt;

   // Glitch filter: the accepted clock level follows the line only after
   // FILTER_CYCLES consecutive cycles at the new level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_flt <= 1'b0;
         flt_cnt <= '0;
      end else if (clk_s2 == clk_flt) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_CYCLES - 1)) begin
         clk_flt <= clk_s2;
         flt_cnt <= '0;
      end else begin
         flt_cnt <= flt_cnt + FW'(1);
      end
   end
`else
   logic unused_filter;
   assign clk_flt       = clk_s2;
   assign unused_filter = (FILTER_CYCLES != 0);
`endif

   // Previous filtered clock level, used for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!reset) clk_flt_q <= 1'b0;
      else        clk_flt_q <= clk_flt;
   end

   assign fall   = clk_flt_q & ~clk_flt;
   assign to_hit = (to_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; disabling receive abandons any frame immediately.
   always_comb begin
      state_nx = state;
      if (!rx_enable) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (fall && !data_s2)                 state_nx = DATA;
            DATA:    if (fall && bit_cnt == 3'd7)          state_nx = PARITY;
                     else if (!fall && to_hit)             state_nx = IDLE;
            PARITY:  if (fall)                             state_nx = STOP;
                     else if (to_hit)                      state_nx = IDLE;
            STOP:    if (fall || to_hit)                   state_nx = IDLE;
            default:                                       state_nx = IDLE;
         endcase
      end
   end

   // Frame outcome decode; framing error has priority over parity error.
   always_comb begin
      good_c = 1'b0;
      perr_c = 1'b0;
      ferr_c = 1'b0;
      terr_c = 1'b0;
      if (rx_enable) begin
         if (state != IDLE && !fall && to_hit) begin
            terr_c = 1'b1;
         end else if (state == STOP && fall) begin
            if (!data_s2)                 ferr_c = 1'b1;
            else if (!(^{shreg, par_q}))  perr_c = 1'b1;
            else                          good_c = 1'b1;
         end
      end
   end

   // Shift register, bit counter, parity capture and inter-edge timeout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bit_cnt <= 3'd0;
         shreg   <= 8'd0;
         par_q   <= 1'b0;
         to_cnt  <= 16'd0;
      end else begin
         if (state == IDLE || fall) to_cnt <= 16'd0;
         else                       to_cnt <= to_cnt + 16'd1;
         if (fall) begin
            case (state)
               IDLE:    bit_cnt <= 3'd0;
               DATA: begin
                  shreg   <= {data_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY:  par_q <= data_s2;
               default: ;
            endcase
         end
      end
   end

   // Registered strobes: each appears the cycle after the deciding edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         received_data    <= 8'd0;
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         framing_error    <= 1'b0;
         timeout_error    <= 1'b0;
      end else begin
         received_data_en <= good_c;
         parity_error     <= perr_c;
         framing_error    <= ferr_c;
         timeout_error    <= terr_c;
         if (good_c) received_data <= shreg;
      end
   end

   assign debug = {2'b00, state};

endmodule

// File: tb/tb_ps2_data_in_rx.sv
// Bench for ps2_data_in_rx: directed PS/2 frames, expected strobes queued on a
// scoreboard and popped by a monitor whenever the DUT raises any strobe.
module tb_ps2_data_in_rx;

   localparam int HALF = 20;   // cycles per half PS/2 bit (shortened bit period)
   localparam int K_GOOD = 0, K_PAR = 1, K_FRM = 2, K_TO = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_enable = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en, parity_error, framing_error, timeout_error;
   logic [3:0] debug;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   ps2_data_in_rx #(.TIMEOUT_CYCLES(5000), .FILTER_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_enable(rx_enable), .received_data(received_data),
      .received_data_en(received_data_en), .parity_error(parity_error),
      .framing_error(framing_error), .timeout_error(timeout_error), .debug(debug)
   );

   always #20 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input logic [7:0] d);
      exp_t e;
      e.kind = kind;
      e.data = d;
      q.push_back(e);
   endtask

   // Drive the first nbits of frame {stop, par, d, start=0}, then idle lines.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int nbits);
      logic [10:0] f;
      f = {stp, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic monitor();
      exp_t e;
      int   nstb, kind;
      forever begin
         @(negedge clk);
         if (reset && (received_data_en || parity_error || framing_error || timeout_error)) begin
            nstb = int'(received_data_en) + int'(parity_error) + int'(framing_error) + int'(timeout_error);
            chk("strobe_onehot", nstb, 1);
            kind = received_data_en ? K_GOOD : parity_error ? K_PAR : framing_error ? K_FRM : K_TO;
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: got kind %0d data %0h expected none", kind, received_data);
            end else begin
               e = q.pop_front();
               chk("strobe_kind", kind, e.kind);
               chk("rx_data", int'(received_data), int'(e.data));
            end
         end
      end
   endtask

   initial begin
      fork monitor(); join_none

      // Reset state
      repeat (5) @(negedge clk);
      chk("rst_data", int'(received_data), 0);
      chk("rst_strobes", int'({received_data_en, parity_error, framing_error, timeout_error}), 0);
      chk("rst_debug", int'(debug), 0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      // 1. 0x55: four ones -> parity 1
      expect_evt(K_GOOD, 8'h55);
      send_frame(8'h55, 1'b1, 1'b1, 11);
      chk("t1_debug_idle", int'(debug), 0);

      // 2. 0x00 and 0xFF, both need parity 1
      expect_evt(K_GOOD, 8'h00);
      send_frame(8'h00, 1'b1, 1'b1, 11);
      expect_evt(K_GOOD, 8'hFF);
      send_frame(8'hFF, 1'b1, 1'b1, 11);

      // 3. 0xA5 has four ones, so parity bit 0 makes the total even -> parity error
      expect_evt(K_PAR, 8'hFF);
      send_frame(8'hA5, 1'b0, 1'b1, 11);
      expect_evt(K_FRM, 8'hFF);
      send_frame(8'h3C, 1'b1, 1'b0, 11);

      // 4. 0x12 stops after start + 4 data bits -> timeout, then 0xF0 ok
      expect_evt(K_TO, 8'hFF);
      send_frame(8'h12, 1'b1, 1'b1, 5);
      chk("t4_debug_mid", int'(debug), 1);
      repeat (5100) @(negedge clk);
      chk("t4_debug_idle", int'(debug), 0);
      expect_evt(K_GOOD, 8'hF0);
      send_frame(8'hF0, 1'b1, 1'b1, 11);

      // 5. receive disabled for a full 0x77 frame -> nothing
      rx_enable = 1'b0;
      send_frame(8'h77, 1'b1, 1'b1, 11);
      chk("t5_debug_dis", int'(debug), 0);
      rx_enable = 1'b1;
      repeat (10) @(negedge clk);

      // 5b. reset in the middle of a 0x1C frame, then a full 0x1C (3 ones, parity 0)
      send_frame(8'h1C, 1'b0, 1'b1, 4);
      chk("t5_debug_mid", int'(debug), 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_rst_data", int'(received_data), 0);
      chk("t5_rst_debug", int'(debug), 0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      expect_evt(K_GOOD, 8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 11);

      // 6. 3-cycle low glitch on ps2_clk in IDLE with data low
      ps2_data = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (15) @(negedge clk);
`ifdef PS2_RX_GLITCH_FILTER_EN
      chk("t6_glitch_state", int'(debug), 0);
`else
      chk("t6_glitch_state", int'(debug), 1);
`endif
      ps2_data = 1'b1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("t6_debug_after_rst", int'(debug), 0);

      // All expected strobes must have appeared
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
